// File: rtl/fetch_pkg.sv
// Shared constants, FSM state type and IF/ID payload for the instruction-fetch stage.
package fetch_pkg;

  localparam int unsigned PC_W   = 32;
  localparam int unsigned INST_W = 32;
  localparam int unsigned CNT_W  = 32;

  localparam logic [INST_W-1:0] NOP_INST = 32'h0000_0013;
  localparam logic [PC_W-1:0]   RESET_PC = '0;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } state_e;

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [INST_W-1:0] inst;
    logic              valid;
  } if_id_t;

  // Empty IF/ID slot seen by decode after reset, flush or halt.
  function automatic if_id_t if_id_bubble();
    if_id_t b;
    b.pc    = '0;
    b.inst  = NOP_INST;
    b.valid = 1'b0;
    return b;
  endfunction

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register: reset and flush insert a bubble, load captures, otherwise hold.
module if_id_reg
  import fetch_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   i_load,
  input  logic   i_flush,
  input  if_id_t i_d,
  output if_id_t o_q
);

  if_id_t r_q;

  always_ff @(posedge clk) begin
    if (rst || i_flush) begin
      r_q <= if_id_bubble();
    end else if (i_load) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives imem, fills IF/ID, handles stall/redirect/halt.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [PC_W-1:0] PC_LIMIT = PC_W'(1024)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              redirect,
  input  logic [PC_W-1:0]   redirect_pc,
  output logic [PC_W-1:0]   imem_pc,
  input  logic [INST_W-1:0] imem_inst,
  output logic [PC_W-1:0]   id_pc,
  output logic [INST_W-1:0] id_inst,
  output logic              id_valid,
  output logic              halted,
  output logic              misalign_err,
  output logic [CNT_W-1:0]  fetch_cnt
);

  state_e            r_state, w_state_nxt;
  logic [PC_W-1:0]   r_pc, w_pc_nxt;
  logic              r_misalign, w_misalign_nxt;
  logic [CNT_W-1:0]  r_fetch_cnt, w_fetch_cnt_nxt;
  logic              w_load, w_flush;
  if_id_t            w_if_id_d, w_if_id_q;

  // State and PC registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= RUN;
      r_pc        <= RESET_PC;
      r_misalign  <= 1'b0;
      r_fetch_cnt <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_pc        <= w_pc_nxt;
      r_misalign  <= w_misalign_nxt;
      r_fetch_cnt <= w_fetch_cnt_nxt;
    end
  end

  // Next-state: redirect beats stall, stall beats normal fetch.
  always_comb begin
    w_state_nxt     = r_state;
    w_pc_nxt        = r_pc;
    w_misalign_nxt  = r_misalign;
    w_fetch_cnt_nxt = r_fetch_cnt;
    w_load          = 1'b0;
    w_flush         = 1'b0;

    if (redirect) begin
      w_pc_nxt    = {redirect_pc[PC_W-1:2], 2'b00};
      w_flush     = 1'b1;
      w_state_nxt = RUN;
      if (redirect_pc[1:0] != 2'b00) begin
        w_misalign_nxt = 1'b1;
      end
    end else if (!stall) begin
      case (r_state)
        RUN: begin
          w_load          = 1'b1;
          w_fetch_cnt_nxt = r_fetch_cnt + CNT_W'(1);
          if (r_pc == PC_LIMIT) begin
            w_state_nxt = HALT;
          end else begin
            w_pc_nxt = r_pc + PC_W'(4);
          end
        end
        HALT: begin
          w_flush = 1'b1;
        end
        default: begin
          w_state_nxt = RUN;
        end
      endcase
    end
  end

  assign w_if_id_d = '{pc: r_pc, inst: imem_inst, valid: 1'b1};

  if_id_reg u_if_id (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_load),
    .i_flush (w_flush),
    .i_d     (w_if_id_d),
    .o_q     (w_if_id_q)
  );

  assign imem_pc      = r_pc;
  assign id_pc        = w_if_id_q.pc;
  assign id_inst      = w_if_id_q.inst;
  assign id_valid     = w_if_id_q.valid;
  assign halted       = (r_state == HALT);
  assign misalign_err = r_misalign;
  assign fetch_cnt    = r_fetch_cnt;

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: driver pushes model expectations, monitor pops and compares.
module tb_fetch_stage;

  localparam logic [31:0] LIMIT = 32'd1024;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic [31:0] imem_pc;
  logic [31:0] imem_inst;
  logic [31:0] id_pc;
  logic [31:0] id_inst;
  logic        id_valid;
  logic        halted;
  logic        misalign_err;
  logic [31:0] fetch_cnt;

  always #5 clk = ~clk;

  fetch_stage dut (
    .clk          (clk),
    .rst          (rst),
    .stall        (stall),
    .redirect     (redirect),
    .redirect_pc  (redirect_pc),
    .imem_pc      (imem_pc),
    .imem_inst    (imem_inst),
    .id_pc        (id_pc),
    .id_inst      (id_inst),
    .id_valid     (id_valid),
    .halted       (halted),
    .misalign_err (misalign_err),
    .fetch_cnt    (fetch_cnt)
  );

  // Program image: fixed words at the addresses the plan names, a hash elsewhere.
  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    case (addr)
      32'd0:    return 32'h0000_0000;
      32'd4:    return 32'h0170_0293;
      32'd12:   return 32'h0300_0293;
      32'd100:  return 32'h0001_a303;
      32'd1024: return 32'h0000_0033;
      default:  return (addr * 32'h9E37_79B1) ^ 32'h5A5A_0000;
    endcase
  endfunction

  assign imem_inst = mem_word(imem_pc);

  typedef struct {
    logic [31:0] pc;
    logic [31:0] id_pc;
    logic [31:0] id_inst;
    logic        id_valid;
    logic        halted;
    logic        mis;
    logic [31:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Reference model of the architectural state seen after each edge.
  logic [31:0] m_pc = 0, m_id_pc = 0, m_id_inst = NOP, m_cnt = 0;
  logic        m_valid = 0, m_halt = 0, m_mis = 0;

  task automatic cycle(input logic r, input logic s, input logic rd, input logic [31:0] rpc);
    exp_t e;
    @(negedge clk);
    rst = r; stall = s; redirect = rd; redirect_pc = rpc;
    if (r) begin
      m_pc = 0; m_id_pc = 0; m_id_inst = NOP; m_valid = 0;
      m_halt = 0; m_mis = 0; m_cnt = 0;
    end else if (rd) begin
      m_pc = rpc & ~32'd3;
      m_id_pc = 0; m_id_inst = NOP; m_valid = 0; m_halt = 0;
      if (rpc % 4 != 0) m_mis = 1;
    end else if (s) begin
      // everything holds
    end else if (!m_halt) begin
      m_id_inst = mem_word(m_pc); m_id_pc = m_pc; m_valid = 1;
      m_cnt = m_cnt + 1;
      if (m_pc == LIMIT) m_halt = 1;
      else m_pc = m_pc + 4;
    end else begin
      m_id_pc = 0; m_id_inst = NOP; m_valid = 0;
    end
    e.pc = m_pc; e.id_pc = m_id_pc; e.id_inst = m_id_inst; e.id_valid = m_valid;
    e.halted = m_halt; e.mis = m_mis; e.cnt = m_cnt;
    exp_q.push_back(e);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: every edge the stage presents its state; compare against the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("imem_pc", imem_pc, e.pc);
        chk("id_valid", 32'(id_valid), 32'(e.id_valid));
        chk("id_inst", id_inst, e.id_inst);
        if (e.id_valid) chk("id_pc", id_pc, e.id_pc);
        chk("halted", 32'(halted), 32'(e.halted));
        chk("misalign_err", 32'(misalign_err), 32'(e.mis));
        chk("fetch_cnt", fetch_cnt, e.cnt);
      end
    end
  end

  initial begin
    int guard;
    logic [31:0] rpc;
    // Reset, then free-run through 0, 4, 8.
    cycle(1, 0, 0, 0);
    cycle(1, 0, 0, 0);
    repeat (3) cycle(0, 0, 0, 0);
    // Stall two cycles at pc 12, then release.
    cycle(0, 1, 0, 0);
    cycle(0, 1, 0, 0);
    cycle(0, 0, 0, 0);
    // Run to pc 40, then redirect to 100 while stalled.
    guard = 0;
    while (m_pc != 40 && guard < 50) begin cycle(0, 0, 0, 0); guard++; end
    cycle(0, 1, 1, 32'd100);
    cycle(0, 0, 0, 0);
    cycle(0, 0, 0, 0);
    // Misaligned redirect sets the sticky flag; an aligned one does not clear it.
    cycle(0, 0, 1, 32'h66);
    repeat (2) cycle(0, 0, 0, 0);
    cycle(0, 0, 1, 32'd96);
    repeat (2) cycle(0, 0, 0, 0);
    // Run to the fetch limit and sit in HALT, including a stall while halted.
    guard = 0;
    while (!m_halt && guard < 400) begin cycle(0, 0, 0, 0); guard++; end
    repeat (3) cycle(0, 0, 0, 0);
    cycle(0, 1, 0, 0);
    cycle(0, 0, 0, 0);
    // Redirect out of HALT back to 4.
    cycle(0, 0, 1, 32'd4);
    repeat (3) cycle(0, 0, 0, 0);
    // Reset mid-run at pc 200.
    guard = 0;
    while (m_pc != 200 && guard < 100) begin cycle(0, 0, 0, 0); guard++; end
    cycle(1, 0, 0, 0);
    repeat (2) cycle(0, 0, 0, 0);
    // PC wraps modulo 2^32 with no side effects.
    cycle(0, 0, 1, 32'hFFFF_FFF8);
    repeat (3) cycle(0, 0, 0, 0);
    // Randomized traffic, biased towards the fetch limit.
    for (int i = 0; i < 600; i++) begin
      logic r, s, rd;
      r  = ($urandom_range(0, 99) < 2);
      s  = ($urandom_range(0, 99) < 25);
      rd = ($urandom_range(0, 99) < 8);
      rpc = ($urandom_range(0, 1) != 0) ? 32'($urandom_range(980, 1030))
                                        : 32'($urandom_range(0, 1100));
      if ($urandom_range(0, 4) != 0) rpc = rpc & ~32'd3;
      cycle(r, s, rd, rpc);
    end
    cycle(0, 0, 0, 0);
    // Drain the scoreboard within a bounded number of edges.
    guard = 0;
    while (exp_q.size() > 0 && guard < 10) begin @(posedge clk); #2; guard++; end
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
